// File: rtl/enemy_shot_controller.sv
// enemy_shot_controller: spawns enemy projectiles under the selected shooter, moves them down,
// resolves hits on the player and owns the lives counter.
module enemy_shot_controller #(
  parameter int LINHAS       = 4,
  parameter int COLUNAS      = 8,
  parameter int N_TIROS      = 2,
  parameter int ATRASO_TIRO  = 2000000,
  parameter int ATRASO_PASSO = 250000,
  parameter int VEL          = 4,
  parameter int ESPACO_X     = 32,
  parameter int ESPACO_Y     = 24,
  parameter int OFFSET_X     = 8,
  parameter int ALT_ENEMY    = 16,
  parameter int JOGADOR_Y    = 440,
  parameter int LARG_JOG     = 32,
  parameter int ALT_JOG      = 16,
  parameter int ALTURA_TELA  = 480,
  parameter int VIDAS        = 3
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      restart,
  input  logic [1:0]                estado_jogo,
  input  logic [LINHAS*COLUNAS-1:0] enemy_vivos,
  input  logic [5:0]                ID_enemy_tiro_X,
  input  logic [5:0]                ID_enemy_tiro_Y,
  input  logic [9:0]                formacao_x,
  input  logic [9:0]                formacao_y,
  input  logic [9:0]                jogador_x,
  output logic [N_TIROS-1:0]        tiro_ativo,
  output logic [10*N_TIROS-1:0]     tiro_x,
  output logic [10*N_TIROS-1:0]     tiro_y,
  output logic [1:0]                vidas,
  output logic                      jogador_vivo,
  output logic                      jogador_atingido
);
  localparam int NE = LINHAS * COLUNAS;
  localparam int TW = ATRASO_TIRO > 1 ? $clog2(ATRASO_TIRO) : 1;
  localparam int PW = ATRASO_PASSO > 1 ? $clog2(ATRASO_PASSO) : 1;
  localparam logic [1:0] VIDAS_INI = 2'(VIDAS);
  logic [TW-1:0] fire_cnt_q, fire_cnt_d;
  logic [PW-1:0] step_cnt_q, step_cnt_d;
  logic [N_TIROS-1:0] ativo_q, ativo_d, hit, off, free_sel;
  logic [N_TIROS-1:0][9:0] x_q, x_d, y_q, y_d;
  logic [1:0] vidas_q, vidas_d;
  logic vivo_q, vivo_d, atingido_q, atingido_d;
  logic fire_now, step_now, fire_ok, taken, dec;
  logic [11:0] col;
  logic [63:0] vivos_ext;
  logic [9:0] spawn_x, spawn_y;
  always_comb begin
    fire_now = fire_cnt_q == TW'(ATRASO_TIRO - 1);
    step_now = step_cnt_q == PW'(ATRASO_PASSO - 1);
    fire_cnt_d = fire_now ? '0 : fire_cnt_q + TW'(1);
    step_cnt_d = step_now ? '0 : step_cnt_q + PW'(1);
    vivos_ext = 64'(enemy_vivos);
    // a negative column wraps to a huge unsigned value and fails the range test
    col = 12'(ID_enemy_tiro_X) - 12'(ID_enemy_tiro_Y) * 12'(COLUNAS);
    spawn_x = formacao_x + 10'(col) * 10'(ESPACO_X) + 10'(OFFSET_X);
    spawn_y = formacao_y + 10'(ID_enemy_tiro_Y) * 10'(ESPACO_Y) + 10'(ALT_ENEMY);
    free_sel = '0;
    taken = 1'b0;
    for (int k = 0; k < N_TIROS; k++) begin
      free_sel[k] = !ativo_q[k] && !taken;
      taken = taken || !ativo_q[k];
    end
    fire_ok = fire_now && estado_jogo == 2'd1 && int'(ID_enemy_tiro_X) < NE &&
              int'(ID_enemy_tiro_Y) < LINHAS && col < 12'(COLUNAS) &&
              vivos_ext[ID_enemy_tiro_X] && taken;
    for (int k = 0; k < N_TIROS; k++) begin
      hit[k] = ativo_q[k] && {1'b0, x_q[k]} >= {1'b0, jogador_x} &&
               {1'b0, x_q[k]} < {1'b0, jogador_x} + 11'(LARG_JOG) &&
               {1'b0, y_q[k]} >= 11'(JOGADOR_Y) && {1'b0, y_q[k]} < 11'(JOGADOR_Y + ALT_JOG);
      off[k] = ativo_q[k] && {1'b0, y_q[k]} >= 11'(ALTURA_TELA);
      ativo_d[k] = (fire_ok && free_sel[k]) || (ativo_q[k] && !hit[k] && !off[k]);
      x_d[k] = fire_ok && free_sel[k] ? spawn_x : x_q[k];
      y_d[k] = fire_ok && free_sel[k] ? spawn_y :
               ativo_q[k] && step_now ? y_q[k] + 10'(VEL) : y_q[k];
    end
    // simultaneous hits cost a single life; lives are frozen outside the running state
    dec = |hit && estado_jogo == 2'd1 && vidas_q != 2'd0;
    vidas_d = dec ? vidas_q - 2'd1 : vidas_q;
    vivo_d = vidas_d != 2'd0;
    atingido_d = dec;
    if (restart) begin
      fire_cnt_d = '0;
      step_cnt_d = '0;
      ativo_d = '0;
      x_d = '0;
      y_d = '0;
      vidas_d = VIDAS_INI;
      vivo_d = VIDAS_INI != 2'd0;
      atingido_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fire_cnt_q <= '0;
      step_cnt_q <= '0;
      ativo_q <= '0;
      x_q <= '0;
      y_q <= '0;
      vidas_q <= VIDAS_INI;
      vivo_q <= VIDAS_INI != 2'd0;
      atingido_q <= 1'b0;
    end else begin
      fire_cnt_q <= fire_cnt_d;
      step_cnt_q <= step_cnt_d;
      ativo_q <= ativo_d;
      x_q <= x_d;
      y_q <= y_d;
      vidas_q <= vidas_d;
      vivo_q <= vivo_d;
      atingido_q <= atingido_d;
    end
  end
  assign tiro_ativo = ativo_q;
  assign tiro_x = x_q;
  assign tiro_y = y_q;
  assign vidas = vidas_q;
  assign jogador_vivo = vivo_q;
  assign jogador_atingido = atingido_q;
endmodule

// File: tb/tb_enemy_shot_controller.sv
// tb_enemy_shot_controller: directed vector tables plus hand sequences for enemy_shot_controller.
module tb_enemy_shot_controller;
  logic clk = 1'b0;
  logic reset, restart;
  logic [1:0] estado_jogo;
  logic [31:0] enemy_vivos;
  logic [5:0] id_x, id_y;
  logic [9:0] formacao_x, formacao_y, jogador_x;
  logic [1:0] tiro_ativo;
  logic [19:0] tiro_x, tiro_y;
  logic [1:0] vidas;
  logic jogador_vivo, jogador_atingido;
  int total = 0, bad = 0, c = 0;
  enemy_shot_controller #(.ATRASO_TIRO(16), .ATRASO_PASSO(4), .VEL(4)) dut (
    .clk(clk), .reset(reset), .restart(restart), .estado_jogo(estado_jogo),
    .enemy_vivos(enemy_vivos), .ID_enemy_tiro_X(id_x), .ID_enemy_tiro_Y(id_y),
    .formacao_x(formacao_x), .formacao_y(formacao_y), .jogador_x(jogador_x),
    .tiro_ativo(tiro_ativo), .tiro_x(tiro_x), .tiro_y(tiro_y), .vidas(vidas),
    .jogador_vivo(jogador_vivo), .jogador_atingido(jogador_atingido)
  );
  always #5 clk = ~clk;
  typedef struct {
    int x, y, fx, fy, est;
    logic [31:0] vivos;
    int act, ex, ey;
  } geo_t;
  typedef struct {
    int jx, est, drop, pulse, vid;
  } fl_t;
  geo_t gv[10];
  fl_t fv[6];
  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
    c++;
  endtask
  task automatic do_restart();
    restart = 1'b1;
    tick();
    restart = 1'b0;
    c = 0;
  endtask
  task automatic wait_fire(output int ok);
    ok = 0;
    for (int t = 0; t < 40 && ok == 0; t++) begin
      tick();
      if (tiro_ativo[0]) ok = 1;
    end
  endtask
  task automatic wait_drop(output int ok, output int pulses);
    ok = 0;
    pulses = 0;
    for (int t = 0; t < 600 && ok == 0; t++) begin
      tick();
      if (jogador_atingido) pulses++;
      if (!tiro_ativo[0]) ok = 1;
    end
  endtask
  initial begin
    int ok, pulses, found, fc, gx, gy;
    gv[0] = '{10, 1, 100, 40, 1, 32'hFFFF_FFFF, 1, 172, 80};
    gv[1] = '{10, 1, 100, 40, 1, 32'hFFFF_FBFF, 0, 0, 0};
    gv[2] = '{40, 1, 100, 40, 1, 32'hFFFF_FFFF, 0, 0, 0};
    gv[3] = '{10, 1, 100, 40, 2, 32'hFFFF_FFFF, 0, 0, 0};
    gv[4] = '{0, 0, 0, 0, 1, 32'hFFFF_FFFF, 1, 8, 16};
    gv[5] = '{31, 3, 100, 40, 1, 32'hFFFF_FFFF, 1, 332, 128};
    gv[6] = '{10, 2, 100, 40, 1, 32'hFFFF_FFFF, 0, 0, 0};
    gv[7] = '{5, 4, 100, 40, 1, 32'hFFFF_FFFF, 0, 0, 0};
    gv[8] = '{7, 0, 1000, 1000, 1, 32'hFFFF_FFFF, 1, 208, 1016};
    gv[9] = '{2, 0, 100, 40, 3, 32'hFFFF_FFFF, 0, 0, 0};
    fv[0] = '{160, 1, 377, 1, 2};
    fv[1] = '{172, 1, 377, 1, 2};
    fv[2] = '{141, 1, 377, 1, 2};
    fv[3] = '{140, 1, 417, 0, 3};
    fv[4] = '{173, 1, 417, 0, 3};
    fv[5] = '{160, 2, 377, 0, 3};
    reset = 1'b1;
    restart = 1'b0;
    estado_jogo = 2'd1;
    enemy_vivos = '1;
    id_x = 6'd40;
    id_y = 6'd0;
    formacao_x = 10'd100;
    formacao_y = 10'd40;
    jogador_x = 10'd400;
    repeat (2) @(posedge clk);
    #1;
    check("rst_vidas", vidas, 3);
    check("rst_vivo", jogador_vivo, 1);
    check("rst_ativo", tiro_ativo, 0);
    check("rst_atingido", jogador_atingido, 0);
    check("rst_x", tiro_x, 0);
    check("rst_y", tiro_y, 0);
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      id_x = 6'(gv[i].x);
      id_y = 6'(gv[i].y);
      formacao_x = 10'(gv[i].fx);
      formacao_y = 10'(gv[i].fy);
      estado_jogo = 2'(gv[i].est);
      enemy_vivos = gv[i].vivos;
      jogador_x = 10'd400;
      do_restart();
      found = 0;
      fc = 0;
      gx = 0;
      gy = 0;
      for (int t = 0; t < 64 && found == 0; t++) begin
        tick();
        if (tiro_ativo != 2'b00) begin
          found = 1;
          fc = c;
          gx = tiro_x[9:0];
          gy = tiro_y[9:0];
        end
      end
      check($sformatf("geo%0d_active", i), found, gv[i].act);
      if (found == 1) begin
        check($sformatf("geo%0d_cycle", i), fc, 16);
        check($sformatf("geo%0d_x", i), gx, gv[i].ex);
        check($sformatf("geo%0d_y", i), gy, gv[i].ey);
      end
    end
    id_x = 6'd0;
    id_y = 6'd0;
    formacao_x = 10'd0;
    formacao_y = 10'd0;
    estado_jogo = 2'd1;
    enemy_vivos = '1;
    jogador_x = 10'd400;
    do_restart();
    repeat (48) tick();
    check("three_ativo", tiro_ativo, 3);
    check("three_y0", tiro_y[9:0], 48);
    check("three_y1", tiro_y[19:10], 32);
    check("three_x0", tiro_x[9:0], 8);
    check("three_x1", tiro_x[19:10], 8);
    for (int i = 0; i < 6; i++) begin
      id_x = 6'd10;
      id_y = 6'd1;
      formacao_x = 10'd100;
      formacao_y = 10'd40;
      estado_jogo = 2'd1;
      jogador_x = 10'(fv[i].jx);
      do_restart();
      wait_fire(ok);
      check($sformatf("fly%0d_fire", i), ok, 1);
      id_x = 6'd40;
      estado_jogo = 2'(fv[i].est);
      wait_drop(ok, pulses);
      check($sformatf("fly%0d_dropped", i), ok, 1);
      check($sformatf("fly%0d_drop_cycle", i), c, fv[i].drop);
      check($sformatf("fly%0d_pulses", i), pulses, fv[i].pulse);
      check($sformatf("fly%0d_vidas", i), vidas, fv[i].vid);
    end
    estado_jogo = 2'd1;
    jogador_x = 10'd160;
    id_x = 6'd40;
    do_restart();
    for (int i = 0; i < 4; i++) begin
      id_x = 6'd10;
      wait_fire(ok);
      check($sformatf("life%0d_fire", i), ok, 1);
      id_x = 6'd40;
      wait_drop(ok, pulses);
      check($sformatf("life%0d_dropped", i), ok, 1);
      check($sformatf("life%0d_pulses", i), pulses, i < 3 ? 1 : 0);
      check($sformatf("life%0d_vidas", i), vidas, i < 2 ? 2 - i : 0);
      check($sformatf("life%0d_vivo", i), jogador_vivo, i < 2 ? 1 : 0);
    end
    id_x = 6'd10;
    wait_fire(ok);
    check("mid_fire", ok, 1);
    id_x = 6'd40;
    repeat (50) tick();
    check("mid_inflight", tiro_ativo[0], 1);
    id_x = 6'd10;
    do_restart();
    check("mid_ativo", tiro_ativo, 0);
    check("mid_x", tiro_x, 0);
    check("mid_y", tiro_y, 0);
    check("mid_vidas", vidas, 3);
    check("mid_vivo", jogador_vivo, 1);
    check("mid_atingido", jogador_atingido, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/enemy_shot_controller.md
Name: enemy_shot_controller

Overview:
Consumer end of the engine's shooter-select interface. Periodically samples the selected shooter (ID_enemy_tiro_X/Y) and spawns an enemy projectile below that enemy, in one of N_TIROS slots. Moves active projectiles downward and detects hits on the player. Owns the lives counter and drives jogador_vivo back to the engine; projectile coordinates go to the renderer.

Parameters:
LINHAS, 4, formation rows
COLUNAS, 8, formation columns (LINHAS*COLUNAS <= 64)
N_TIROS, 2, simultaneous enemy projectile slots
ATRASO_TIRO, 2000000, cycles between fire attempts
ATRASO_PASSO, 250000, cycles between projectile steps
VEL, 4, pixels per step
ESPACO_X, 32, horizontal enemy pitch (px)
ESPACO_Y, 24, vertical enemy pitch (px)
OFFSET_X, 8, spawn x offset within enemy cell
ALT_ENEMY, 16, enemy sprite height
JOGADOR_Y, 440, player top y
LARG_JOG, 32, player width
ALT_JOG, 16, player height
ALTURA_TELA, 480, screen height
VIDAS, 3, initial lives (1..3)

Ports:
clk  in  1  system clock
reset  in  1  asynchronous active-high reset
restart  in  1  synchronous clear from engine (same effect as reset)
estado_jogo  in  2  1 = running, 2 = player won, 3 = player lost
enemy_vivos  in  LINHAS*COLUNAS  alive mask, bit i = linear enemy index i
ID_enemy_tiro_X  in  6  linear index of selected shooter
ID_enemy_tiro_Y  in  6  row of selected shooter
formacao_x  in  10  formation top-left x
formacao_y  in  10  formation top-left y
jogador_x  in  10  player left x
tiro_ativo  out  N_TIROS  slot active flags
tiro_x  out  10*N_TIROS  packed slot x, slot k at [10k+9:10k]
tiro_y  out  10*N_TIROS  packed slot y
vidas  out  2  remaining lives
jogador_vivo  out  1  vidas != 0
jogador_atingido  out  1  one-cycle hit pulse

Behaviour:
- Reset (async) or restart (sync): all slots inactive, tiro_x/tiro_y = 0, both counters = 0, vidas = VIDAS, jogador_vivo = 1, jogador_atingido = 0.
- Fire counter counts 0..ATRASO_TIRO-1 and wraps. Fire attempt occurs at the edge where count == ATRASO_TIRO-1.
- Fire is valid only if all hold: estado_jogo == 1; X < LINHAS*COLUNAS; Y < LINHAS; col = X - Y*COLUNAS < COLUNAS; enemy_vivos[X] == 1; a free slot exists. Otherwise the attempt is dropped silently; there is no queuing.
- On a valid fire, the lowest-index free slot loads at that edge: x = formacao_x + col*ESPACO_X + OFFSET_X, y = formacao_y + Y*ESPACO_Y + ALT_ENEMY. Arithmetic is 10-bit truncating. tiro_ativo rises the following cycle (registered outputs).
- Step counter counts 0..ATRASO_PASSO-1. At the wrap edge, every slot that was already active adds VEL to y. A slot loaded on the same edge does not move.
- Each cycle, for every active slot, evaluated on registered values:
  - hit = x >= jogador_x, x < jogador_x+LARG_JOG, y >= JOGADOR_Y, y < JOGADOR_Y+ALT_JOG (11-bit compare, no wrap).
  - off = y >= ALTURA_TELA.
- Resolution at the next edge:
  - Hit slots are freed, and hit takes precedence over off.
  - Off slots are freed.
  - If any slot hit and vidas > 0: vidas decrements by exactly 1 (multiple simultaneous hits cost one life), and jogador_atingido = 1 for that single cycle.
- vidas saturates at 0; jogador_vivo = (vidas != 0), registered together with vidas.
- While estado_jogo != 1: no new fires, existing projectiles keep moving and colliding, and vidas is frozen (hits still free slots but cost nothing).
- A freed slot is reusable on the same edge it is freed? No — a slot becomes reusable on the edge after it is freed.
- Restart mid-flight clears everything on the next edge, with priority over fire, step and hit.

Test Plan:
- Reset with VIDAS=3 -> vidas=3, jogador_vivo=1, tiro_ativo=0, jogador_atingido=0.
- ATRASO_TIRO=16, formacao=(100,40), X=10, Y=1, enemy_vivos all 1, estado=1 -> slot0 active, tiro_x=172, tiro_y=80.
- Same setup but enemy_vivos[10]=0, or X=40, or estado=2 -> no slot activates over 64 cycles.
- N_TIROS=2, three fire attempts with no steps -> slots 0 and 1 active, third attempt dropped.
- Shot at x=172 falling, jogador_x=160, ATRASO_PASSO=4, VEL=4 -> when y reaches 440, slot freed next edge, vidas 3->2, one-cycle pulse. Repeating this until vidas=0 -> jogador_vivo=0 and further hits leave vidas at 0.
- Shot with jogador_x=400 -> passes the player, freed at y >= 480, vidas unchanged. Assert restart mid-flight -> all slots cleared and vidas restored to 3 the next cycle.
